// File: rtl/sev_dec_twelve_hr.sv
// Purpose: decode a 24-hour binary hour (0..23) into two 12-hour seven-segment digits plus a PM flag.
// Latency: 1 cycle, registered outputs, new input accepted every cycle.
// Backpressure: none, no handshake; SEVDEC_LEAD_ZERO_BLANK_EN blanks the leading tens zero for 1..9.
module sev_dec_twelve_hr (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  a_in,
    output logic [13:0] out,
    output logic        pm
);

    // Segment patterns, abcdefg with segment a in the MSB, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

`ifdef SEVDEC_LEAD_ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = SEG_BLANK;
`else
    localparam logic [6:0] TENS_ZERO = 7'b0000001;
`endif

    function automatic logic [6:0] seg_digit(input logic [3:0] dig);
        logic [6:0] seg;
        case (dig)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    logic [13:0] out_d, out_q;
    logic        pm_d,  pm_q;
    logic [7:0]  disp_val;
    logic [7:0]  ones_val;
    logic        tens_one;

    // Map the 24-hour value onto 1..12, split into digits and encode
    always_comb begin
        disp_val = 8'd0;
        ones_val = 8'd0;
        tens_one = 1'b0;
        out_d    = {SEG_DASH, SEG_DASH};
        pm_d     = 1'b0;
        if (a_in < 8'd24) begin
            if (a_in == 8'd0) begin
                disp_val = 8'd12;
            end else if (a_in <= 8'd12) begin
                disp_val = a_in;
            end else begin
                disp_val = a_in - 8'd12;
            end
            pm_d     = (a_in >= 8'd12);
            tens_one = (disp_val >= 8'd10);
            ones_val = tens_one ? (disp_val - 8'd10) : disp_val;
            out_d    = {(tens_one ? seg_digit(4'd1) : TENS_ZERO), seg_digit(ones_val[3:0])};
        end
    end

    // Output register; reset blanks the display and wins over the input
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= {SEG_BLANK, SEG_BLANK};
            pm_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            pm_q  <= pm_d;
        end
    end

    assign out = out_q;
    assign pm  = pm_q;

endmodule

// File: tb/tb_sev_dec_twelve_hr.sv
// Purpose: directed, table-driven check of the 12-hour seven-segment hour decoder.
// Latency: expects outputs one rising edge after the input is applied.
// Backpressure: not applicable; inputs are driven every cycle on the falling edge.
module tb_sev_dec_twelve_hr;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b1111110;
`ifdef SEVDEC_LEAD_ZERO_BLANK_EN
    localparam logic [6:0] TZ = BL;
`else
    localparam logic [6:0] TZ = S0;
`endif

    typedef struct {
        logic [7:0]  a;
        logic [13:0] exp_out;
        logic        exp_pm;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a_in;
    logic [13:0] out;
    logic        pm;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    sev_dec_twelve_hr dut (
        .clk   (clk),
        .reset (reset),
        .a_in  (a_in),
        .out   (out),
        .pm    (pm)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] a, input logic [6:0] t, input logic [6:0] o, input logic p);
        vec_t v;
        v.a = a;
        v.exp_out = {t, o};
        v.exp_pm = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [13:0] eo, input logic ep);
        total++;
        if (out !== eo || pm !== ep) begin
            bad++;
            $display("FAIL %s: got out=%b pm=%b, expected out=%b pm=%b", name, out, pm, eo, ep);
        end
    endtask

    // Drive on the falling edge, sample on the next falling edge (one rising edge later)
    task automatic step(input logic r, input logic [7:0] a);
        reset = r;
        a_in  = a;
        @(negedge clk);
    endtask

    initial begin
        // Sweep 0..23 consecutively, then illegal inputs and a repeat of "11"
        vecs.push_back(mk(8'd0,  S1, S2, 1'b0));
        vecs.push_back(mk(8'd1,  TZ, S1, 1'b0));
        vecs.push_back(mk(8'd2,  TZ, S2, 1'b0));
        vecs.push_back(mk(8'd3,  TZ, S3, 1'b0));
        vecs.push_back(mk(8'd4,  TZ, S4, 1'b0));
        vecs.push_back(mk(8'd5,  TZ, S5, 1'b0));
        vecs.push_back(mk(8'd6,  TZ, S6, 1'b0));
        vecs.push_back(mk(8'd7,  TZ, S7, 1'b0));
        vecs.push_back(mk(8'd8,  TZ, S8, 1'b0));
        vecs.push_back(mk(8'd9,  TZ, S9, 1'b0));
        vecs.push_back(mk(8'd10, S1, S0, 1'b0));
        vecs.push_back(mk(8'd11, S1, S1, 1'b0));
        vecs.push_back(mk(8'd12, S1, S2, 1'b1));
        vecs.push_back(mk(8'd13, TZ, S1, 1'b1));
        vecs.push_back(mk(8'd14, TZ, S2, 1'b1));
        vecs.push_back(mk(8'd15, TZ, S3, 1'b1));
        vecs.push_back(mk(8'd16, TZ, S4, 1'b1));
        vecs.push_back(mk(8'd17, TZ, S5, 1'b1));
        vecs.push_back(mk(8'd18, TZ, S6, 1'b1));
        vecs.push_back(mk(8'd19, TZ, S7, 1'b1));
        vecs.push_back(mk(8'd20, TZ, S8, 1'b1));
        vecs.push_back(mk(8'd21, TZ, S9, 1'b1));
        vecs.push_back(mk(8'd22, S1, S0, 1'b1));
        vecs.push_back(mk(8'd23, S1, S1, 1'b1));
        vecs.push_back(mk(8'd24, DA, DA, 1'b0));
        vecs.push_back(mk(8'd30, DA, DA, 1'b0));
        vecs.push_back(mk(8'd255, DA, DA, 1'b0));
        vecs.push_back(mk(8'd128, DA, DA, 1'b0));
        vecs.push_back(mk(8'd11, S1, S1, 1'b0));

        reset = 1'b1;
        a_in  = 8'd11;
        @(negedge clk);
        step(1'b1, 8'd11);
        check("reset_state", 14'h3FFF, 1'b0);

        // First decode after release: "11" (14'h27CF)
        step(1'b0, 8'd11);
        check("first_after_reset", 14'h27CF, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b0, vecs[i].a);
            check($sformatf("vec_a%0d", vecs[i].a), vecs[i].exp_out, vecs[i].exp_pm);
        end

        // Reset mid-sweep: blank on next edge, then "05" one cycle after release
        step(1'b0, 8'd14);
        check("pre_reset_14", {TZ, S2}, 1'b1);
        step(1'b1, 8'd15);
        check("mid_reset_blank", {BL, BL}, 1'b0);
        step(1'b1, 8'd12);
        check("reset_priority", {BL, BL}, 1'b0);
        step(1'b0, 8'd5);
        check("after_reset_5", {TZ, S5}, 1'b0);

        // Back-to-back changes: each output tracks the prior cycle's input
        step(1'b0, 8'd255);
        check("b2b_255", {DA, DA}, 1'b0);
        step(1'b0, 8'd0);
        check("b2b_0", {S1, S2}, 1'b0);
        step(1'b0, 8'd13);
        check("b2b_13", {TZ, S1}, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
